// File: rtl/aes_pkg.sv
// Shared widths and loader state encoding for the AES input loader.
package aes_pkg;

   localparam int AES_BLOCK_W     = 128;
   localparam int WORD_W          = 32;
   localparam int WORDS_PER_BLOCK = 4;

   typedef enum logic [1:0] {
      ST_FILL = 2'd0,
      ST_FIRE = 2'd1,
      ST_WAIT = 2'd2
   } ld_state_t;

endpackage

// File: rtl/word_assembler.sv
// Packs 32-bit words MSB-first into a 128-bit block; flags a full block.
module word_assembler
   import aes_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_en,
   input  logic [WORD_W-1:0]      in_word,
   input  logic                   clr_full,
   output logic [AES_BLOCK_W-1:0] data,
   output logic                   full
);

   logic [AES_BLOCK_W-1:0] data_q, data_d;
   logic [1:0]             cnt_q, cnt_d;
   logic                   full_q, full_d;

   always_comb begin
      data_d = data_q;
      cnt_d  = cnt_q;
      full_d = full_q;
      if (clr_full)
         full_d = 1'b0;
      // Any word after a completed block starts a new one and drops full.
      if (in_en) begin
         data_d = {data_q[AES_BLOCK_W-WORD_W-1:0], in_word};
         cnt_d  = cnt_q + 2'd1;
         full_d = (cnt_q == 2'(WORDS_PER_BLOCK - 1));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q <= '0;
         cnt_q  <= '0;
         full_q <= 1'b0;
      end else begin
         data_q <= data_d;
         cnt_q  <= cnt_d;
         full_q <= full_d;
      end
   end

   assign data = data_q;
   assign full = full_q;

endmodule

// File: rtl/aes_input_loader.sv
// Collects key and plaintext words, fires the encryptor, waits for done.
module aes_input_loader
   import aes_pkg::*;
#(
   parameter int KEY_PERSIST = 1,
   parameter int CNT_W       = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WORD_W-1:0]      in_data,
   input  logic                   in_valid,
   input  logic                   in_is_key,
   output logic                   in_ready,
   output logic [AES_BLOCK_W-1:0] plaintext,
   output logic [AES_BLOCK_W-1:0] key,
   output logic                   start,
   input  logic                   enc_done,
   output logic                   busy,
   output logic                   key_valid,
   output logic [CNT_W-1:0]       blocks_sent
);

   ld_state_t        state_q, state_d;
   logic [CNT_W-1:0] blocks_q, blocks_d;
   logic             pt_full;
   logic             done_clr;
   logic             key_clr;
   logic             key_en;
   logic             pt_en;

   always_comb begin
      state_d  = state_q;
      blocks_d = blocks_q;
      in_ready = 1'b0;
      start    = 1'b0;
      busy     = 1'b0;
      done_clr = 1'b0;
      unique case (state_q)
         ST_FILL: begin
            in_ready = in_is_key | ~pt_full;
            if (pt_full && key_valid)
               state_d = ST_FIRE;
         end
         ST_FIRE: begin
            start    = 1'b1;
            busy     = 1'b1;
            blocks_d = blocks_q + CNT_W'(1);
            state_d  = ST_WAIT;
         end
         ST_WAIT: begin
            busy = 1'b1;
            if (enc_done) begin
               state_d  = ST_FILL;
               done_clr = 1'b1;
            end
         end
         default: state_d = ST_FILL;
      endcase
   end

   assign key_en  = in_valid & in_ready & in_is_key;
   assign pt_en   = in_valid & in_ready & ~in_is_key;
   assign key_clr = done_clr & (KEY_PERSIST == 0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_FILL;
         blocks_q <= '0;
      end else begin
         state_q  <= state_d;
         blocks_q <= blocks_d;
      end
   end

   word_assembler u_key (
      .clk      (clk),
      .rst      (rst),
      .in_en    (key_en),
      .in_word  (in_data),
      .clr_full (key_clr),
      .data     (key),
      .full     (key_valid)
   );

   word_assembler u_pt (
      .clk      (clk),
      .rst      (rst),
      .in_en    (pt_en),
      .in_word  (in_data),
      .clr_full (done_clr),
      .data     (plaintext),
      .full     (pt_full)
   );

   assign blocks_sent = blocks_q;

endmodule

// File: doc/aes_input_loader.md
AES_INPUT_LOADER -- requirements
Module: aes_input_loader

Interface
REQ-001 SHALL have parameter KEY_PERSIST, default 1, meaning: 1 = key is retained across blocks; 0 = a fresh key is required for every block.
REQ-002 SHALL have parameter CNT_W, default 16, meaning: width of the block counter.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous and active-low.
REQ-005 SHALL have port in_data, input, 32, input word.
REQ-006 SHALL have port in_valid, input, 1, in_data is valid this cycle.
REQ-007 SHALL have port in_is_key, input, 1, word belongs to the key (1) or to the plaintext (0).
REQ-008 SHALL have port in_ready, output, 1, loader accepts a word this cycle.
REQ-009 SHALL have port plaintext, output, 128, assembled block presented to the encryptor.
REQ-010 SHALL have port key, output, 128, assembled key presented to the encryptor.
REQ-011 SHALL have port start, output, 1, one-cycle pulse requesting encryption.
REQ-012 SHALL have port enc_done, input, 1, encryptor completion, sampled in WAIT only.
REQ-013 SHALL have port busy, output, 1, high in FIRE and WAIT.
REQ-014 SHALL have port key_valid, output, 1, a full 128-bit key is held.
REQ-015 SHALL have port blocks_sent, output, CNT_W, count of start pulses issued.

Function
REQ-016 A word SHALL be accepted when in_valid and in_ready are both high in the same cycle.
REQ-017 Words SHALL be packed MSB-first: the first word goes to [127:96] and the fourth to [31:0], for both key and plaintext.
REQ-018 The state machine SHALL have the states FILL, FIRE and WAIT.
REQ-019 In FILL, in_ready SHALL equal in_is_key OR NOT pt_full; in FIRE and WAIT, in_ready SHALL be 0.
REQ-020 pt_full SHALL set on acceptance of the 4th plaintext word.
REQ-021 The plaintext word counter SHALL wrap 3->0 at that acceptance.
REQ-022 The first key word accepted after key_valid=1, or after a completed key, SHALL clear key_valid in the same cycle.
REQ-023 key_valid SHALL set on acceptance of the 4th key word.
REQ-024 Interleaving key and plaintext words SHALL be legal; each stream keeps its own counter.
REQ-025 FILL SHALL go to FIRE on the first cycle in which registered pt_full and key_valid are both 1.
REQ-026 FIRE SHALL last exactly one cycle.
REQ-027 start SHALL be 1 only in FIRE.
REQ-028 blocks_sent SHALL increment in FIRE and wrap modulo 2^CNT_W.
REQ-029 FIRE SHALL always go to WAIT.
REQ-030 WAIT SHALL go to FILL on the cycle after enc_done=1 is sampled.
REQ-031 On WAIT->FILL, pt_full SHALL clear.
REQ-032 On WAIT->FILL with KEY_PERSIST=0, key_valid SHALL also clear.
REQ-033 enc_done outside WAIT SHALL be ignored.
REQ-034 plaintext and key outputs SHALL hold constant from FIRE until the WAIT->FILL transition.
REQ-035 A partial key load, 1-3 words, SHALL leave key_valid=0; the next key word continues the count.
REQ-036 Latency SHALL be 2 cycles from the acceptance of the completing word (4th plaintext word or 4th key word) to start=1.

Reset
REQ-037 Asserting rst=0 SHALL, asynchronously: set state to FILL; set in_ready to 1; set start to 0; set busy to 0; set key_valid to 0; clear pt_full; clear both word counters; set blocks_sent to 0; set plaintext to 0; set key to 0.
REQ-038 Reset asserted mid-WAIT SHALL abandon the block; a later enc_done SHALL not affect state.
REQ-039 Reset deassertion SHALL be synchronised externally; the first accepted word SHALL be the one on the first rising edge after rst=1.

Structure
REQ-040 aes_pkg SHALL hold AES_BLOCK_W=128, WORD_W=32, WORDS_PER_BLOCK=4 and the loader state enum.
REQ-041 One sub-module, word_assembler (32-to-128 MSB-first shift register with 2-bit count and full flag), SHALL be instantiated twice: once for key and once for plaintext.

Verification
REQ-042 Key words 00010203, 04050607, 08090a0b, 0c0d0e0f, then plaintext words 00112233, 44556677, 8899aabb, ccddeeff -> key=000102030405060708090a0b0c0d0e0f, plaintext=00112233445566778899aabbccddeeff, start pulses 1 cycle, 2 cycles after the last word; blocks_sent=1.
REQ-043 Plaintext loaded with no key -> no start and in_ready=0 for in_is_key=0; load the key -> start 2 cycles after the 4th key word.
REQ-044 KEY_PERSIST=1, enc_done after 10 cycles, second plaintext block -> start with no key reload, key unchanged; KEY_PERSIST=0 -> no start until 4 new key words.
REQ-045 enc_done pulsed in FILL, and words offered in WAIT -> ignored: state unchanged, in_ready=0 in WAIT, no word lost after returning to FILL.
REQ-046 rst=0 asserted 3 cycles into WAIT -> all outputs at reset values immediately; enc_done afterwards -> no effect; blocks_sent=0.
REQ-047 CNT_W=4, 17 blocks -> blocks_sent=1 after wrap.
